// File: rtl/split_check_sched_pkg.sv
// Shared types and helpers for the split-constraint checker sequencer.
package split_check_sched_pkg;

    localparam int MAX_SPLITS = 16;
    localparam int MAX_IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } nsb_t;

    // Lowest set bit of mask at or above 'from'; found=0 if none.
    function automatic nsb_t next_set_bit(
        input logic [MAX_SPLITS-1:0] mask,
        input logic [MAX_IDX_W:0]    from
    );
        nsb_t r;
        r = '0;
        for (int i = MAX_SPLITS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                r.found = 1'b1;
                r.idx   = MAX_IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/split_check_sched_stat_cnt.sv
// Saturating statistics counter (pass / fail result tallies).
module split_stat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/split_check_sched.sv
// Walks the enabled split checkers one per cycle with early exit on the
// first failing split; returns pass/fail plus the failing split index.
module split_check_sched
    import split_check_sched_pkg::*;
#(
    parameter int NUM_SPLITS = 4,
    parameter int VEC_W      = 64,
    parameter int ID_W       = 4,
    parameter int CNT_W      = 16,
    localparam int IDX_W     = $clog2(NUM_SPLITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cand_valid,
    output logic                  cand_ready,
    input  logic [VEC_W-1:0]      cand_data,
    input  logic [ID_W-1:0]       cand_id,
    input  logic [NUM_SPLITS-1:0] split_en,
    output logic [VEC_W-1:0]      eval_vec,
    output logic [IDX_W-1:0]      split_sel,
    input  logic [NUM_SPLITS-1:0] split_x,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_pass,
    output logic [ID_W-1:0]       res_id,
    output logic [IDX_W-1:0]      res_fail_idx,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt
);

    sched_state_t          state_q, state_d;
    logic [VEC_W-1:0]      vec_q, vec_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [NUM_SPLITS-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  pass_q, pass_d;
    logic [IDX_W-1:0]      fidx_q, fidx_d;
    logic                  inc_pass, inc_fail;
    nsb_t                  first, nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            id_q    <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            pass_q  <= 1'b0;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            id_q    <= id_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            fidx_q  <= fidx_d;
        end
    end

    assign first = next_set_bit(MAX_SPLITS'(split_en), '0);
    assign nxt   = next_set_bit(MAX_SPLITS'(mask_q),
                                (MAX_IDX_W + 1)'(idx_q) + 1'b1);

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        id_d       = id_q;
        mask_d     = mask_q;
        idx_d      = idx_q;
        pass_d     = pass_q;
        fidx_d     = fidx_q;
        cand_ready = 1'b0;
        res_valid  = 1'b0;
        inc_pass   = 1'b0;
        inc_fail   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cand_ready = 1'b1;
                if (cand_valid) begin
                    vec_d  = cand_data;
                    id_d   = cand_id;
                    mask_d = split_en;
                    fidx_d = '0;
                    if (first.found) begin
                        idx_d   = IDX_W'(first.idx);
                        state_d = EVAL;
                    end else begin
                        pass_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            EVAL: begin
                if (!split_x[idx_q]) begin
                    pass_d  = 1'b0;
                    fidx_d  = idx_q;
                    state_d = DONE;
                end else if (!nxt.found) begin
                    pass_d  = 1'b1;
                    fidx_d  = '0;
                    state_d = DONE;
                end else begin
                    idx_d = IDX_W'(nxt.idx);
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    inc_pass = pass_q;
                    inc_fail = !pass_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign eval_vec     = vec_q;
    assign split_sel    = idx_q;
    assign res_pass     = pass_q;
    assign res_id       = id_q;
    assign res_fail_idx = fidx_q;

    split_stat_cnt #(.CNT_W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_pass),
        .cnt   (pass_cnt)
    );

    split_stat_cnt #(.CNT_W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_fail),
        .cnt   (fail_cnt)
    );

endmodule

// File: tb/tb_split_check_sched.sv
// Directed self-checking bench for split_check_sched.
module tb_split_check_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cand_valid;
    logic        cand_ready;
    logic [63:0] cand_data;
    logic [3:0]  cand_id;
    logic [3:0]  split_en;
    logic [63:0] eval_vec;
    logic [1:0]  split_sel;
    logic [3:0]  split_x;
    logic        res_valid;
    logic        res_ready;
    logic        res_pass;
    logic [3:0]  res_id;
    logic [1:0]  res_fail_idx;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    split_check_sched #(
        .NUM_SPLITS(4), .VEC_W(64), .ID_W(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cand_valid(cand_valid), .cand_ready(cand_ready),
        .cand_data(cand_data), .cand_id(cand_id),
        .split_en(split_en), .eval_vec(eval_vec),
        .split_sel(split_sel), .split_x(split_x),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pass(res_pass), .res_id(res_id),
        .res_fail_idx(res_fail_idx),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".cand_ready"}, 64'(cand_ready), 64'd1);
        chk({tag, ".eval_vec"}, eval_vec, 64'd0);
        chk({tag, ".split_sel"}, 64'(split_sel), 64'd0);
        chk({tag, ".res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, ".res_pass"}, 64'(res_pass), 64'd0);
        chk({tag, ".res_id"}, 64'(res_id), 64'd0);
        chk({tag, ".res_fail_idx"}, 64'(res_fail_idx), 64'd0);
        chk({tag, ".pass_cnt"}, 64'(pass_cnt), 64'd0);
        chk({tag, ".fail_cnt"}, 64'(fail_cnt), 64'd0);
    endtask

    // Called at a negedge; returns at the negedge where res_valid is seen.
    task automatic offer_and_wait(
        input logic [3:0] en, input logic [3:0] x, input logic [3:0] id,
        input logic [63:0] data, output int lat, output logic [15:0] seq
    );
        cand_valid = 1'b1;
        split_en   = en;
        split_x    = x;
        cand_id    = id;
        cand_data  = data;
        chk("offer.cand_ready", 64'(cand_ready), 64'd1);
        @(posedge clk);
        #1;
        cand_valid = 1'b0;
        split_en   = 4'h0;
        cand_data  = 64'hDEAD_DEAD_DEAD_DEAD;
        lat = 0;
        seq = 16'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (res_valid) break;
            seq = {seq[11:0], 2'b00, split_sel};
        end
    endtask

    task automatic handshake;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
    endtask

    int          lat;
    logic [15:0] seq;
    int          bad;
    logic [3:0]  id_hold;
    logic        pass_hold;
    logic [1:0]  fidx_hold;

    initial begin
        rst_n      = 1'b0;
        cand_valid = 1'b0;
        cand_data  = '0;
        cand_id    = '0;
        split_en   = '0;
        split_x    = '0;
        res_ready  = 1'b0;
        #2;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full pass
        offer_and_wait(4'b1111, 4'b1111, 4'd3, 64'h0123_4567_89AB_CDEF,
                       lat, seq);
        chk("full.latency", 64'(lat), 64'd5);
        chk("full.sel_seq", 64'(seq), 64'h0123);
        chk("full.res_valid", 64'(res_valid), 64'd1);
        chk("full.res_pass", 64'(res_pass), 64'd1);
        chk("full.res_id", 64'(res_id), 64'd3);
        chk("full.fail_idx", 64'(res_fail_idx), 64'd0);
        chk("full.eval_vec", eval_vec, 64'h0123_4567_89AB_CDEF);
        chk("full.cand_ready", 64'(cand_ready), 64'd0);
        handshake();
        chk("full.pass_cnt", 64'(pass_cnt), 64'd1);
        chk("full.fail_cnt", 64'(fail_cnt), 64'd0);
        chk("full.idle_ready", 64'(cand_ready), 64'd1);

        // Early exit at split 2
        offer_and_wait(4'b1111, 4'b1011, 4'd7, 64'hAAAA_0000_5555_FFFF,
                       lat, seq);
        chk("early.latency", 64'(lat), 64'd4);
        chk("early.sel_seq", 64'(seq), 64'h0012);
        chk("early.res_pass", 64'(res_pass), 64'd0);
        chk("early.res_id", 64'(res_id), 64'd7);
        chk("early.fail_idx", 64'(res_fail_idx), 64'd2);
        handshake();
        chk("early.pass_cnt", 64'(pass_cnt), 64'd1);
        chk("early.fail_cnt", 64'(fail_cnt), 64'd1);

        // Mask skip: split 0 fails but is disabled
        offer_and_wait(4'b1010, 4'b1110, 4'd9, 64'h1, lat, seq);
        chk("skip.latency", 64'(lat), 64'd3);
        chk("skip.sel_seq", 64'(seq), 64'h0013);
        chk("skip.res_pass", 64'(res_pass), 64'd1);
        chk("skip.fail_idx", 64'(res_fail_idx), 64'd0);
        chk("skip.res_id", 64'(res_id), 64'd9);
        handshake();
        chk("skip.pass_cnt", 64'(pass_cnt), 64'd2);

        // Zero mask
        offer_and_wait(4'b0000, 4'b0000, 4'd1, 64'h2, lat, seq);
        chk("zero.latency", 64'(lat), 64'd1);
        chk("zero.res_pass", 64'(res_pass), 64'd1);
        chk("zero.fail_idx", 64'(res_fail_idx), 64'd0);
        handshake();
        chk("zero.pass_cnt", 64'(pass_cnt), 64'd3);
        chk("zero.fail_cnt", 64'(fail_cnt), 64'd1);

        // Backpressure with a second candidate waiting
        offer_and_wait(4'b1111, 4'b1111, 4'd5, 64'h3, lat, seq);
        chk("bp.latency", 64'(lat), 64'd5);
        id_hold    = res_id;
        pass_hold  = res_pass;
        fidx_hold  = res_fail_idx;
        chk("bp.id_a", 64'(id_hold), 64'd5);
        cand_valid = 1'b1;
        cand_id    = 4'd12;
        cand_data  = 64'hBBBB;
        split_en   = 4'b0001;
        split_x    = 4'b0000;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cand_ready !== 1'b0 || res_valid !== 1'b1 ||
                res_id !== id_hold || res_pass !== pass_hold ||
                res_fail_idx !== fidx_hold || eval_vec !== 64'h3)
                bad++;
        end
        chk("bp.stall_cycles_bad", 64'(bad), 64'd0);
        handshake();
        chk("bp.ready_after_hs", 64'(cand_ready), 64'd1);
        chk("bp.pass_cnt", 64'(pass_cnt), 64'd4);
        @(posedge clk);
        #1;
        cand_valid = 1'b0;
        @(negedge clk);
        chk("bp.b_accepted", 64'(cand_ready), 64'd0);
        chk("bp.b_vec", eval_vec, 64'hBBBB);
        @(negedge clk);
        chk("bp.b_res_valid", 64'(res_valid), 64'd1);
        chk("bp.b_res_pass", 64'(res_pass), 64'd0);
        chk("bp.b_res_id", 64'(res_id), 64'd12);
        chk("bp.b_fail_idx", 64'(res_fail_idx), 64'd0);
        handshake();
        chk("bp.fail_cnt", 64'(fail_cnt), 64'd2);

        // Reset mid-EVAL
        offer_and_wait(4'b1111, 4'b1111, 4'd6, 64'h77, lat, seq);
        handshake();
        cand_valid = 1'b1;
        split_en   = 4'b1111;
        split_x    = 4'b1111;
        cand_id    = 4'd8;
        cand_data  = 64'hCAFE;
        @(posedge clk);
        #1;
        cand_valid = 1'b0;
        @(negedge clk);
        chk("rst.in_eval_sel", 64'(split_sel), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) bad++;
        end
        chk("rst.no_result", 64'(bad), 64'd0);
        chk("rst.pass_cnt", 64'(pass_cnt), 64'd0);

        // Saturation
        force dut.u_pass_cnt.cnt_q = 16'hFFFF;
        #1;
        release dut.u_pass_cnt.cnt_q;
        @(negedge clk);
        chk("sat.preset", 64'(pass_cnt), 64'hFFFF);
        offer_and_wait(4'b0000, 4'b0000, 4'd2, 64'h4, lat, seq);
        chk("sat.res_pass", 64'(res_pass), 64'd1);
        handshake();
        chk("sat.pass_cnt", 64'(pass_cnt), 64'hFFFF);
        chk("sat.fail_cnt", 64'(fail_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
